spi_loader_sched: RTL and testbench
===================================

Name: spi_loader_sched

Overview:
Controller and 2-way arbiter in front of the SPI flash loader (FIFO interface: init/fill/empty/low/rd/dout/load_done).
- Sequences the loader init.
- Arbitrates burst requests from two consumers, e.g. RISC-V code fetch and accelerator weight fetch.
- Throttles flash fill against FIFO occupancy.
- Pops the FIFO and delivers exactly the requested word count to the granted consumer over a valid/ready port.

Parameters:
LEN_W, 16, width of the burst length (words) per request
TO_W, 12, watchdog counter width; only used when SPI_SCHED_TIMEOUT_EN is defined

Ports:
clk  input  1  clock, same as the loader/RISC-V clock
resetn  input  1  asynchronous active-low reset
i_start  input  1  pulse: run the loader init sequence
o_ready  output  1  init complete; scheduler accepting requests
o_init  output  1  to loader i_init; one-cycle pulse
o_fill  output  1  to loader i_fill; level
i_fifo_empty  input  1  from loader
i_fifo_low  input  1  from loader
o_fifo_rd  output  1  to loader; pops one word
i_fifo_dout  input  32  from loader; first-word-fall-through, valid while !i_fifo_empty
i_load_done  input  1  from loader; init complete
i_req0, i_req1  input  1  burst request; held until the matching o_gnt
i_len0, i_len1  input  LEN_W  burst length in words; sampled on grant
o_gnt0, o_gnt1  output  1  level, high for the whole burst
o_vld0, o_vld1  output  1  data valid to requester
i_rdy0, i_rdy1  input  1  requester ready
o_last  output  1  qualifies the final word of the burst
o_data  output  32  shared data to both requesters
o_err  output  1  watchdog abort flag (sticky); tied 0 without the feature

Behaviour:
- Reset (async, resetn=0):
  - All outputs 0; state=IDLE.
  - rr pointer=1, so req0 wins the first tie.
  - Remaining count=0; output register empty.
- All outputs are registered.
- State IDLE:
  - i_start → INIT, with o_init=1 for exactly one cycle.
  - Requests are ignored.
- State INIT:
  - Wait for i_load_done=1, then → READY with o_ready=1 (o_ready stays 1 until reset).
  - i_start is ignored.
- State READY:
  - i_start → INIT: o_ready drops, o_init pulses.
  - Otherwise grant among asserted requests.
  - Single requester: grant it.
  - Both requesting: grant the one not last granted.
  - On grant: latch len into rem, set o_gntN, update rr pointer, → XFER.
  - A len=0 grant → DONE directly, with o_gnt high one cycle and no data.
- State XFER (output register = data_q/vld_q, driven to the granted requester only):
  - Pop condition: rem!=0 && !i_fifo_empty && (!vld_q || rdy_granted).
  - On pop: o_fifo_rd=1 (combinational from registered state), data_q<=i_fifo_dout, vld_q<=1, rem<=rem-1, o_last<=(rem==1).
  - Handshake: transfer when vld && rdy; vld_q clears if no new pop that cycle.
  - Data and o_last are held stable while vld && !rdy.
  - Latency: 1 cycle from FIFO non-empty to o_vld.
  - Throughput: 1 word/cycle with rdy held high.
  - Fill: o_fill=1 while rem!=0 && i_fifo_low; 0 when rem==0.
  - → DONE when the last word is accepted (vld && rdy && o_last).
- State DONE:
  - o_gnt, o_vld, o_last cleared; → READY next cycle.
  - Minimum 1 idle cycle between bursts.
  - Requests are not sampled in DONE.
- Boundaries:
  - FIFO empty mid-burst: stall, vld_q=0, no pop.
  - rem==0 with FIFO non-empty: no pop; extra words stay for the next burst.
  - Requester drops rdy: no pop while vld_q && !rdy.
  - i_req dropped after grant: ignored; the burst completes.
  - len = 2^LEN_W-1: no wrap; rem counts to 0.
  - Reset mid-burst: immediate return to IDLE; FIFO contents are undefined to the scheduler.

Optional Feature:
Macro SPI_SCHED_TIMEOUT_EN.
- Defined:
  - In XFER a TO_W-bit counter increments each cycle with no pop and no handshake, and clears on either.
  - On all-ones: abort the burst, set o_err=1 (sticky until reset), clear o_gnt/o_vld, → READY.
  - rem is discarded.
- Not defined:
  - No counter; o_err tied 0; XFER waits indefinitely.

Test Plan:
- Init: reset, i_start pulse, i_load_done asserted 10 cycles later → o_init high exactly 1 cycle; o_ready=1 on the cycle after i_load_done; no grant before it.
- Single burst: req0 len=4, FIFO holding 0xA0..0xA3, rdy0=1 → o_gnt0; o_vld0 on 4 consecutive cycles with 0xA0..0xA3; o_last on 0xA3; 4 o_fifo_rd pulses; o_gnt0 low the next cycle.
- Round-robin: req0 and req1 both held, len=2 each → grant order 0,1,0,1; each burst exactly 2 words; ≥1 cycle gap between grants.
- Backpressure/starve: len=8, FIFO empty for 5 cycles mid-burst, and rdy1 toggled 1010 → no pop while vld&&!rdy; o_fill=1 whenever i_fifo_low && rem!=0; word order preserved; exactly 8 words delivered.
- Edge: len=0 grant → o_gnt high 1 cycle, zero pops. Reset asserted mid-burst after word 3 of 6 → all outputs 0 immediately; state IDLE.
- Timeout (SPI_SCHED_TIMEOUT_EN, TO_W=4): burst of len=3 with FIFO held empty after word 1 → abort 15 cycles later; o_err=1 and stays; next request is granted normally.

Source files
------------

// File: rtl/spi_loader_sched.sv
// Init sequencer, 2-way round-robin arbiter and FIFO-to-requester burst mover for the SPI flash loader.
// Optional burst watchdog enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_loader_sched #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned TO_W  = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    output logic             o_ready,
    output logic             o_init,
    output logic             o_fill,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_low,
    output logic             o_fifo_rd,
    input  logic [31:0]      i_fifo_dout,
    input  logic             i_load_done,
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic [LEN_W-1:0] i_len0,
    input  logic [LEN_W-1:0] i_len1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_vld0,
    output logic             o_vld1,
    input  logic             i_rdy0,
    input  logic             i_rdy1,
    output logic             o_last,
    output logic [31:0]      o_data,
    output logic             o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READY,
        S_XFER,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;       // last granted requester
    logic             sel_q, sel_d;     // requester owning the current burst
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      data_q, data_d;
    logic             vld0_q, vld0_d, vld1_q, vld1_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             init_q, init_d;
    logic             ready_q, ready_d;
    logic             fill_q, fill_d;

    logic             vld, rdy_g, hs, pop, to_exp;

`ifdef SPI_SCHED_TIMEOUT_EN
    logic [TO_W-1:0]  to_q, to_d;
    logic             err_q, err_d;

    assign to_exp = (state_q == S_XFER) && (to_q == '1);
    assign o_err  = err_q;
`else
    logic [TO_W-1:0]  unused_to;

    assign unused_to = '0;
    assign to_exp    = 1'b0;
    assign o_err     = 1'b0;
`endif

    assign vld       = vld0_q | vld1_q;
    assign rdy_g     = sel_q ? i_rdy1 : i_rdy0;
    assign hs        = vld && rdy_g;
    // Refill the output register only when it is empty or being drained this cycle.
    assign pop       = (state_q == S_XFER) && (rem_q != '0) && !i_fifo_empty
                       && (!vld || rdy_g) && !to_exp;
    assign o_fifo_rd = pop;

    assign o_ready = ready_q;
    assign o_init  = init_q;
    assign o_fill  = fill_q;
    assign o_gnt0  = gnt0_q;
    assign o_gnt1  = gnt1_q;
    assign o_vld0  = vld0_q;
    assign o_vld1  = vld1_q;
    assign o_last  = last_q;
    assign o_data  = data_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        data_d  = data_q;
        vld0_d  = vld0_q;
        vld1_d  = vld1_q;
        last_d  = last_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        init_d  = 1'b0;
        ready_d = ready_q;
`ifdef SPI_SCHED_TIMEOUT_EN
        to_d    = '0;
        err_d   = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_INIT;
                    init_d  = 1'b1;
                end
            end
            S_INIT: begin
                if (i_load_done) begin
                    state_d = S_READY;
                    ready_d = 1'b1;
                end
            end
            S_READY: begin
                if (i_start) begin
                    state_d = S_INIT;
                    ready_d = 1'b0;
                    init_d  = 1'b1;
                end else if (i_req0 && (!i_req1 || rr_q)) begin
                    sel_d   = 1'b0;
                    rr_d    = 1'b0;
                    gnt0_d  = 1'b1;
                    rem_d   = i_len0;
                    state_d = (i_len0 == '0) ? S_DONE : S_XFER;
                end else if (i_req1) begin
                    sel_d   = 1'b1;
                    rr_d    = 1'b1;
                    gnt1_d  = 1'b1;
                    rem_d   = i_len1;
                    state_d = (i_len1 == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (to_exp) begin
                    state_d = S_READY;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    vld0_d  = 1'b0;
                    vld1_d  = 1'b0;
                    last_d  = 1'b0;
                    rem_d   = '0;
`ifdef SPI_SCHED_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end else begin
                    if (pop) begin
                        data_d = i_fifo_dout;
                        vld0_d = !sel_q;
                        vld1_d = sel_q;
                        rem_d  = rem_q - LEN_W'(1);
                        last_d = (rem_q == LEN_W'(1));
                    end else if (hs) begin
                        vld0_d = 1'b0;
                        vld1_d = 1'b0;
                        last_d = 1'b0;
                    end
                    if (hs && last_q) begin
                        state_d = S_DONE;
                        gnt0_d  = 1'b0;
                        gnt1_d  = 1'b0;
                        vld0_d  = 1'b0;
                        vld1_d  = 1'b0;
                        last_d  = 1'b0;
                    end
`ifdef SPI_SCHED_TIMEOUT_EN
                    to_d = (pop || hs) ? '0 : to_q + TO_W'(1);
`endif
                end
            end
            S_DONE: begin
                state_d = S_READY;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                vld0_d  = 1'b0;
                vld1_d  = 1'b0;
                last_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        fill_d = (state_d == S_XFER) && (rem_d != '0) && i_fifo_low;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b1;
            sel_q   <= 1'b0;
            rem_q   <= '0;
            data_q  <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            last_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            init_q  <= 1'b0;
            ready_q <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            init_q  <= init_d;
            ready_q <= ready_d;
            fill_q  <= fill_d;
        end
    end

`ifdef SPI_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_loader_sched.sv
// Directed bench for spi_loader_sched with a behavioural FWFT FIFO in front of it.
module tb_spi_loader_sched;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             resetn;
    logic             i_start, i_fifo_low, i_load_done;
    logic             i_req0, i_req1, i_rdy0, i_rdy1;
    logic [LEN_W-1:0] i_len0, i_len1;
    logic             o_ready, o_init, o_fill, o_fifo_rd;
    logic             o_gnt0, o_gnt1, o_vld0, o_vld1, o_last, o_err;
    logic [31:0]      o_data;
    logic             fifo_empty;
    logic [31:0]      fifo_dout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]  mem [0:255];
    int unsigned  wr_ptr = 0;
    int unsigned  rd_ptr = 0;
    int unsigned  pops   = 0;

    logic [31:0]  rx_data [$];
    bit           rx_last [$];
    bit           rx_who  [$];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = mem[rd_ptr[7:0]];

    spi_loader_sched #(.LEN_W(LEN_W), .TO_W(4)) dut (
        .clk(clk), .resetn(resetn), .i_start(i_start), .o_ready(o_ready),
        .o_init(o_init), .o_fill(o_fill), .i_fifo_empty(fifo_empty),
        .i_fifo_low(i_fifo_low), .o_fifo_rd(o_fifo_rd), .i_fifo_dout(fifo_dout),
        .i_load_done(i_load_done), .i_req0(i_req0), .i_req1(i_req1),
        .i_len0(i_len0), .i_len1(i_len1), .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_vld0(o_vld0), .o_vld1(o_vld1), .i_rdy0(i_rdy0), .i_rdy1(i_rdy1),
        .o_last(o_last), .o_data(o_data), .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_fifo_rd === 1'b1) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    always @(posedge clk) begin
        if (resetn) begin
            if (o_vld0 && i_rdy0) begin
                rx_data.push_back(o_data); rx_last.push_back(o_last); rx_who.push_back(1'b0);
            end
            if (o_vld1 && i_rdy1) begin
                rx_data.push_back(o_data); rx_last.push_back(o_last); rx_who.push_back(1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic rx_flush();
        rx_data.delete(); rx_last.delete(); rx_who.delete();
    endtask

    task automatic wait_gnt(input bit which, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if ((which ? o_gnt1 : o_gnt0) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic reset_init();
        i_req0 = 0; i_req1 = 0; i_start = 0; i_load_done = 0;
        resetn = 0;
        tick();
        wr_ptr = rd_ptr;
        resetn = 1;
        tick();
        i_start = 1; tick(); i_start = 0;
        i_load_done = 1; tick(); i_load_done = 0;
        tick();
        rx_flush();
    endtask

    task automatic test_reset();
        resetn = 0; i_start = 0; i_fifo_low = 0; i_load_done = 0;
        i_req0 = 0; i_req1 = 0; i_rdy0 = 0; i_rdy1 = 0; i_len0 = '0; i_len1 = '0;
        repeat (3) tick();
        n_cmp++;
        if ({o_ready, o_init, o_fill, o_fifo_rd, o_gnt0, o_gnt1, o_vld0, o_vld1, o_last, o_err} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000000000",
                     {o_ready, o_init, o_fill, o_fifo_rd, o_gnt0, o_gnt1, o_vld0, o_vld1, o_last, o_err});
        end
        n_cmp++;
        if (o_data !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 00000000", o_data);
        end
        resetn = 1;
        tick();
    endtask

    task automatic test_init();
        int  init_hi = 0;
        bit  gnt_seen = 0;
        i_req0 = 1; i_len0 = 16'd4;
        repeat (2) begin tick(); gnt_seen |= (o_gnt0 | o_gnt1); end
        i_start = 1; tick(); i_start = 0;
        init_hi += int'(o_init);
        for (int k = 0; k < 10; k++) begin
            tick();
            init_hi += int'(o_init);
            gnt_seen |= (o_gnt0 | o_gnt1);
        end
        n_cmp++;
        if (o_ready !== 1'b0) begin n_bad++; $display("FAIL init_ready_early: got %b want 0", o_ready); end
        i_load_done = 1;
        tick();
        gnt_seen |= (o_gnt0 | o_gnt1);
        n_cmp++;
        if (o_ready !== 1'b1) begin n_bad++; $display("FAIL init_ready: got %b want 1", o_ready); end
        i_load_done = 0; i_req0 = 0;
        n_cmp++;
        if (init_hi !== 1) begin n_bad++; $display("FAIL init_pulse_len: got %0d want 1", init_hi); end
        repeat (2) begin tick(); gnt_seen |= (o_gnt0 | o_gnt1); end
        n_cmp++;
        if (gnt_seen !== 1'b0) begin n_bad++; $display("FAIL init_no_grant: got %b want 0", gnt_seen); end
    endtask

    task automatic test_single_burst();
        bit ok;
        int unsigned p0;
        rx_flush();
        for (int i = 0; i < 4; i++) push(32'hA0 + i);
        p0 = pops;
        i_fifo_low = 0; i_rdy0 = 1; i_len0 = 16'd4; i_req0 = 1;
        wait_gnt(1'b0, ok);
        i_req0 = 0;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_grant: got timeout want o_gnt0"); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({o_vld0, o_last, o_data} !== {1'b1, (i == 3), 32'hA0 + 32'(i)}) begin
                n_bad++;
                $display("FAIL single_word%0d: got vld=%b last=%b data=%h want vld=1 last=%b data=%h",
                         i, o_vld0, o_last, o_data, (i == 3), 32'hA0 + 32'(i));
            end
        end
        tick();
        n_cmp++;
        if ({o_gnt0, o_vld0} !== 2'b00) begin n_bad++; $display("FAIL single_gnt_drop: got %b want 00", {o_gnt0, o_vld0}); end
        n_cmp++;
        if (pops - p0 !== 4) begin n_bad++; $display("FAIL single_pops: got %0d want 4", pops - p0); end
    endtask

    task automatic test_round_robin();
        bit order [$];
        bit pg0 = 0, pg1 = 0, done = 0;
        int idle = 0, min_gap = 99;
        reset_init();
        for (int i = 0; i < 8; i++) push(32'hB0 + i);
        i_rdy0 = 1; i_rdy1 = 1; i_len0 = 16'd2; i_len1 = 16'd2; i_req0 = 1; i_req1 = 1;
        for (int k = 0; k < 80 && !done; k++) begin
            tick();
            if ((o_gnt0 && !pg0) || (o_gnt1 && !pg1)) begin
                if (order.size() > 0 && idle < min_gap) min_gap = idle;
                order.push_back(o_gnt1);
                idle = 0;
            end
            if (!o_gnt0 && !o_gnt1) idle++;
            if (order.size() == 4) begin i_req0 = 0; i_req1 = 0; end
            if (order.size() == 4 && !o_gnt0 && !o_gnt1) done = 1;
            pg0 = o_gnt0; pg1 = o_gnt1;
        end
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL rr_timeout: got %0d grants want 4", order.size()); end
        n_cmp++;
        if (order.size() != 4 || {order[0], order[1], order[2], order[3]} !== 4'b0101) begin
            n_bad++; $display("FAIL rr_order: got %p want 0,1,0,1", order);
        end
        n_cmp++;
        if (min_gap < 1) begin n_bad++; $display("FAIL rr_gap: got %0d want >=1", min_gap); end
        n_cmp++;
        if (rx_data.size() != 8) begin
            n_bad++; $display("FAIL rr_count: got %0d want 8", rx_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if ({rx_who[i], rx_last[i], rx_data[i]} !== {(i / 2) % 2 == 1, (i % 2) == 1, 32'hB0 + 32'(i)}) begin
                    n_bad++;
                    $display("FAIL rr_word%0d: got who=%b last=%b data=%h want who=%b last=%b data=%h",
                             i, rx_who[i], rx_last[i], rx_data[i], (i / 2) % 2 == 1, (i % 2) == 1, 32'hB0 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int unsigned base;
        int empty_cyc = 0, viol_bp = 0, viol_fill = 0, viol_empty = 0;
        bit pushed = 0, seen = 0, done = 0;
        rx_flush();
        for (int i = 0; i < 3; i++) push(32'hC0 + i);
        base = pops;
        i_fifo_low = 1; i_len1 = 16'd8; i_req1 = 1; i_rdy1 = 1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(posedge clk); #1;
            i_rdy1 = (cyc % 2 == 0);
            if (!pushed && (pops - base) == 3 && fifo_empty) begin
                empty_cyc++;
                if (empty_cyc == 5) begin
                    for (int i = 3; i < 8; i++) push(32'hC0 + i);
                    pushed = 1;
                end
            end
            #1;
            if (o_gnt1) begin seen = 1; i_req1 = 0; end
            if (o_vld1 && !i_rdy1 && o_fifo_rd) viol_bp++;
            if (fifo_empty && o_fifo_rd) viol_empty++;
            if (o_fill !== (o_gnt1 && (pops - base) < 8)) viol_fill++;
            if (seen && !o_gnt1) done = 1;
        end
        i_fifo_low = 0; i_rdy1 = 1;
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL bp_timeout: got burst open want done"); end
        n_cmp++;
        if (viol_bp != 0) begin n_bad++; $display("FAIL bp_pop_while_stalled: got %0d want 0", viol_bp); end
        n_cmp++;
        if (viol_empty != 0) begin n_bad++; $display("FAIL bp_pop_when_empty: got %0d want 0", viol_empty); end
        n_cmp++;
        if (viol_fill != 0) begin n_bad++; $display("FAIL bp_fill: got %0d bad cycles want 0", viol_fill); end
        n_cmp++;
        if (pops - base !== 8) begin n_bad++; $display("FAIL bp_pops: got %0d want 8", pops - base); end
        n_cmp++;
        if (rx_data.size() != 8) begin
            n_bad++; $display("FAIL bp_count: got %0d want 8", rx_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if ({rx_who[i], rx_last[i], rx_data[i]} !== {1'b1, (i == 7), 32'hC0 + 32'(i)}) begin
                    n_bad++;
                    $display("FAIL bp_word%0d: got who=%b last=%b data=%h want who=1 last=%b data=%h",
                             i, rx_who[i], rx_last[i], rx_data[i], (i == 7), 32'hC0 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_len_zero();
        bit ok;
        int gnt_hi = 1;
        bit vld_seen = 0;
        int unsigned p0;
        rx_flush();
        push(32'hD0);
        p0 = pops;
        i_len0 = 16'd0; i_req0 = 1; i_rdy0 = 1;
        wait_gnt(1'b0, ok);
        i_req0 = 0;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL len0_grant: got timeout want o_gnt0"); end
        for (int k = 0; k < 4; k++) begin
            tick();
            gnt_hi += int'(o_gnt0);
            vld_seen |= o_vld0;
        end
        n_cmp++;
        if (gnt_hi !== 1) begin n_bad++; $display("FAIL len0_gnt_cycles: got %0d want 1", gnt_hi); end
        n_cmp++;
        if ({vld_seen, pops - p0 == 0} !== 2'b01) begin
            n_bad++; $display("FAIL len0_no_data: got vld=%b pops=%0d want vld=0 pops=0", vld_seen, pops - p0);
        end
        i_len0 = 16'd1; i_req0 = 1;
        wait_gnt(1'b0, ok);
        i_req0 = 0;
        repeat (4) tick();
        n_cmp++;
        if (rx_data.size() != 1 || {rx_last[0], rx_data[0]} !== {1'b1, 32'hD0}) begin
            n_bad++; $display("FAIL len0_leftover: got %0d words want 1 word D0 with last", rx_data.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        bit reached = 0;
        rx_flush();
        for (int i = 0; i < 6; i++) push(32'hE0 + i);
        i_len0 = 16'd6; i_req0 = 1; i_rdy0 = 1;
        wait_gnt(1'b0, ok);
        i_req0 = 0;
        for (int k = 0; k < 20 && !reached; k++) begin
            tick();
            if (rx_data.size() >= 3) reached = 1;
        end
        n_cmp++;
        if (!reached) begin n_bad++; $display("FAIL rst_mid_progress: got %0d words want 3", rx_data.size()); end
        resetn = 0;
        #1;
        n_cmp++;
        if ({o_ready, o_init, o_fill, o_fifo_rd, o_gnt0, o_gnt1, o_vld0, o_vld1, o_last, o_err, o_data} !== 42'b0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got ctrl=%b data=%h want all 0",
                     {o_ready, o_init, o_fill, o_fifo_rd, o_gnt0, o_gnt1, o_vld0, o_vld1, o_last, o_err}, o_data);
        end
        tick();
        wr_ptr = rd_ptr;
        resetn = 1;
        push(32'hEE);
        i_len0 = 16'd1; i_req0 = 1;
        repeat (4) tick();
        n_cmp++;
        if (o_gnt0 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle_grant: got %b want 0", o_gnt0); end
        i_req0 = 0;
        i_start = 1; tick(); i_start = 0;
        n_cmp++;
        if (o_init !== 1'b1) begin n_bad++; $display("FAIL rst_mid_idle_init: got %b want 1", o_init); end
    endtask

`ifdef SPI_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int to_cyc = 0;
        bit fired = 0;
        reset_init();
        push(32'hF0);
        i_len0 = 16'd3; i_req0 = 1; i_rdy0 = 1;
        wait_gnt(1'b0, ok);
        i_req0 = 0;
        for (int k = 0; k < 40 && !fired; k++) begin
            tick();
            to_cyc++;
            if (o_err === 1'b1) fired = 1;
        end
        n_cmp++;
        if (!fired || to_cyc != 18) begin
            n_bad++; $display("FAIL to_abort: got fired=%b after %0d cycles want fired=1 after 18", fired, to_cyc);
        end
        n_cmp++;
        if ({o_gnt0, o_vld0} !== 2'b00) begin n_bad++; $display("FAIL to_clear: got %b want 00", {o_gnt0, o_vld0}); end
        rx_flush();
        for (int i = 0; i < 3; i++) push(32'hF8 + i);
        i_req0 = 1;
        wait_gnt(1'b0, ok);
        i_req0 = 0;
        repeat (6) tick();
        n_cmp++;
        if ({ok, rx_data.size() == 3, o_err} !== 3'b111) begin
            n_bad++; $display("FAIL to_recover: got ok=%b words=%0d err=%b want 1/3/1", ok, rx_data.size(), o_err);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_init();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_len_zero();
        test_reset_mid_burst();
`ifdef SPI_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
